// File: rtl/fuzzy_pkg.sv
// Shared constants, state encoding and helpers for the interval type-2 fuzzy rule-evaluation stage.
// Membership and firing degrees are unsigned LARG-bit values.
package fuzzy_pkg;

  localparam int N_CONJ   = 3;
  localparam int N_REGRAS = 9;
  localparam int LARG     = 8;

  localparam logic [1:0]            REGRA_OFF     = 2'd3;
  localparam logic [2*N_REGRAS-1:0] REGRAS_PADRAO = 18'h29910;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } estado_t;

  function automatic logic [LARG-1:0] min_larg(input logic [LARG-1:0] a,
                                               input logic [LARG-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [LARG-1:0] max_larg(input logic [LARG-1:0] a,
                                               input logic [LARG-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/regra_t2.sv
// Combinational firing of one rule: selects set i of input 1 and set j of input 2, min t-norm.
// Zero latency; no flow control.
module regra_t2
  import fuzzy_pkg::*;
(
  input  logic [N_CONJ*LARG-1:0] e1_up,
  input  logic [N_CONJ*LARG-1:0] e1_low,
  input  logic [N_CONJ*LARG-1:0] e2_up,
  input  logic [N_CONJ*LARG-1:0] e2_low,
  input  logic [1:0]             i,
  input  logic [1:0]             j,
  output logic [LARG-1:0]        up,
  output logic [LARG-1:0]        low
);

  logic [LARG-1:0] a_up, a_low, b_up, b_low;

  always_comb begin
    a_up  = '0;
    a_low = '0;
    b_up  = '0;
    b_low = '0;
    for (int s = 0; s < N_CONJ; s++) begin
      if (i == 2'(s)) begin
        a_up  = e1_up[s*LARG +: LARG];
        a_low = e1_low[s*LARG +: LARG];
      end
      if (j == 2'(s)) begin
        b_up  = e2_up[s*LARG +: LARG];
        b_low = e2_low[s*LARG +: LARG];
      end
    end
  end

  assign up  = min_larg(a_up, b_up);
  assign low = min_larg(a_low, b_low);

endmodule

// File: rtl/inferencia_t2.sv
// Sequential 9-rule evaluation (min t-norm, max aggregation) into 3 interval type-2 output sets.
// start sampled at T, results and one-cycle EN_saida after edge T+10; start while busy is dropped.
module inferencia_t2
  import fuzzy_pkg::*;
#(
  parameter logic [2*N_REGRAS-1:0] REGRAS = REGRAS_PADRAO
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_CONJ*LARG-1:0] E1_UP,
  input  logic [N_CONJ*LARG-1:0] E1_LOW,
  input  logic [N_CONJ*LARG-1:0] E2_UP,
  input  logic [N_CONJ*LARG-1:0] E2_LOW,
  output logic [LARG-1:0]        FOU_1_UP,
  output logic [LARG-1:0]        FOU_2_UP,
  output logic [LARG-1:0]        FOU_3_UP,
  output logic [LARG-1:0]        FOU_1_LOW,
  output logic [LARG-1:0]        FOU_2_LOW,
  output logic [LARG-1:0]        FOU_3_LOW,
  output logic                   EN_saida,
  output logic                   busy
);

  estado_t state, state_nxt;

  logic [3:0]             k;
  logic [1:0]             ri, rj, rc;
  logic [LARG-1:0]        up_k, low_k;
  logic [N_CONJ*LARG-1:0] e1_up_q, e1_low_q, e2_up_q, e2_low_q;
  logic [LARG-1:0]        acc_up  [N_CONJ];
  logic [LARG-1:0]        acc_low [N_CONJ];
  logic [LARG-1:0]        fou_up  [N_CONJ];
  logic [LARG-1:0]        fou_low [N_CONJ];
  logic                   en_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EVAL;
      EVAL:    if (k == 4'(N_REGRAS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ri = 2'(k / 4'd3);
  assign rj = 2'(k % 4'd3);
  assign rc = REGRAS[{k, 1'b0} +: 2];

  regra_t2 u_regra (
    .e1_up  (e1_up_q),
    .e1_low (e1_low_q),
    .e2_up  (e2_up_q),
    .e2_low (e2_low_q),
    .i      (ri),
    .j      (rj),
    .up     (up_k),
    .low    (low_k)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      e1_up_q  <= '0;
      e1_low_q <= '0;
      e2_up_q  <= '0;
      e2_low_q <= '0;
      en_q     <= 1'b0;
      for (int s = 0; s < N_CONJ; s++) begin
        acc_up[s]  <= '0;
        acc_low[s] <= '0;
        fou_up[s]  <= '0;
        fou_low[s] <= '0;
      end
    end else begin
      state <= state_nxt;
      en_q  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            k       <= '0;
            e1_up_q <= E1_UP;
            e2_up_q <= E2_UP;
            // Clamp lower bounds under the upper ones so FOU_LOW never exceeds FOU_UP.
            for (int s = 0; s < N_CONJ; s++) begin
              e1_low_q[s*LARG +: LARG] <= min_larg(E1_LOW[s*LARG +: LARG], E1_UP[s*LARG +: LARG]);
              e2_low_q[s*LARG +: LARG] <= min_larg(E2_LOW[s*LARG +: LARG], E2_UP[s*LARG +: LARG]);
              acc_up[s]  <= '0;
              acc_low[s] <= '0;
            end
          end
        end
        EVAL: begin
          k <= k + 4'd1;
          if (rc != REGRA_OFF) begin
            acc_up[rc]  <= max_larg(acc_up[rc], up_k);
            acc_low[rc] <= max_larg(acc_low[rc], low_k);
          end
        end
        DONE: begin
          k <= '0;
          for (int s = 0; s < N_CONJ; s++) begin
            fou_up[s]  <= acc_up[s];
            fou_low[s] <= acc_low[s];
          end
        end
        default: k <= '0;
      endcase
    end
  end

  assign FOU_1_UP  = fou_up[0];
  assign FOU_2_UP  = fou_up[1];
  assign FOU_3_UP  = fou_up[2];
  assign FOU_1_LOW = fou_low[0];
  assign FOU_2_LOW = fou_low[1];
  assign FOU_3_LOW = fou_low[2];
  assign EN_saida  = en_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_inferencia_t2.sv
// Directed bench for inferencia_t2: default rule table plus an all-disabled instance.
module tb_inferencia_t2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] e1_up = '0, e1_low = '0, e2_up = '0, e2_low = '0;

  logic [7:0] a1u, a2u, a3u, a1l, a2l, a3l;
  logic [7:0] b1u, b2u, b3u, b1l, b2l, b3l;
  logic       en_a, busy_a, en_b, busy_b;

  int total = 0;
  int bad   = 0;

  int pulse_a, pulse_b, npulse_a, npulse_b, busy_mid, hold_mid;

  always #5 clk = ~clk;

  inferencia_t2 dut_a (
    .clk(clk), .rst(rst), .start(start),
    .E1_UP(e1_up), .E1_LOW(e1_low), .E2_UP(e2_up), .E2_LOW(e2_low),
    .FOU_1_UP(a1u), .FOU_2_UP(a2u), .FOU_3_UP(a3u),
    .FOU_1_LOW(a1l), .FOU_2_LOW(a2l), .FOU_3_LOW(a3l),
    .EN_saida(en_a), .busy(busy_a)
  );

  inferencia_t2 #(.REGRAS(18'h3FFFF)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .E1_UP(e1_up), .E1_LOW(e1_low), .E2_UP(e2_up), .E2_LOW(e2_low),
    .FOU_1_UP(b1u), .FOU_2_UP(b2u), .FOU_3_UP(b3u),
    .FOU_1_LOW(b1l), .FOU_2_LOW(b2l), .FOU_3_LOW(b3l),
    .EN_saida(en_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] u1, input logic [7:0] u2,
                         input logic [7:0] u3, input logic [7:0] l1, input logic [7:0] l2,
                         input logic [7:0] l3);
    check({tag, ".fou1_up"},  a1u, u1);
    check({tag, ".fou2_up"},  a2u, u2);
    check({tag, ".fou3_up"},  a3u, u3);
    check({tag, ".fou1_low"}, a1l, l1);
    check({tag, ".fou2_low"}, a2l, l2);
    check({tag, ".fou3_low"}, a3l, l3);
  endtask

  // Pulse start for edge T, then watch edges T+1..T+14 for EN_saida.
  task automatic run(input int extra_start_at, input int change_at);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    pulse_a = -1; pulse_b = -1; npulse_a = 0; npulse_b = 0;
    busy_mid = 0; hold_mid = 0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      if (en_a) begin npulse_a++; pulse_a = n; end
      if (en_b) begin npulse_b++; pulse_b = n; end
      if (n == 5) begin busy_mid = int'(busy_a); hold_mid = int'(a1u); end
      @(negedge clk);
      start = (n + 1 == extra_start_at);
      if (n + 1 == change_at) begin
        e1_up = 24'h123456; e1_low = 24'h654321;
        e2_up = 24'hABCDEF; e2_low = 24'h0F0F0F;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #12;
    check("rst.en", en_a, 0);
    check("rst.busy", busy_a, 0);
    check_a("rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle.busy", busy_a, 0);
    check("idle.en", en_a, 0);

    // All sets UP=255 LOW=128; inputs scrambled mid-run must not matter.
    e1_up = 24'hFFFFFF; e1_low = 24'h808080; e2_up = 24'hFFFFFF; e2_low = 24'h808080;
    run(0, 3);
    check("full.pulse_at", pulse_a, 10);
    check("full.npulse", npulse_a, 1);
    check("full.busy_mid", busy_mid, 1);
    check("full.hold_mid", hold_mid, 0);
    check_a("full", 255, 255, 255, 128, 128, 128);
    check("off.pulse_at", pulse_b, 10);
    check("off.npulse", npulse_b, 1);
    check("off.sum", 32'(b1u) + b2u + b3u + b1l + b2l + b3l, 0);
    check("idle_after.busy", busy_a, 0);

    // Sets 3..1: E1_UP={0,200,100}, E2_UP={0,60,180}.
    e1_up = 24'h00C864; e1_low = 24'h0; e2_up = 24'h003CB4; e2_low = 24'h0;
    run(0, 0);
    check("pat.pulse_at", pulse_a, 10);
    check("pat.hold_mid", hold_mid, 255);
    check_a("pat", 180, 60, 0, 0, 0, 0);

    // Inverted low on E1 set1 is clamped to its upper degree.
    e1_up = 24'h000032; e1_low = 24'h00005A; e2_up = 24'h0000C8; e2_low = 24'h0000C8;
    run(0, 0);
    check("inv.pulse_at", pulse_a, 10);
    check("inv.hold_mid", hold_mid, 180);
    check_a("inv", 50, 0, 0, 50, 0, 0);

    // Second start at T+4 is ignored: a single pulse, none at T+14.
    e1_up = 24'hFFFFFF; e1_low = 24'h808080; e2_up = 24'hFFFFFF; e2_low = 24'h808080;
    run(4, 0);
    check("busy_start.pulse_at", pulse_a, 10);
    check("busy_start.npulse", npulse_a, 1);
    check_a("busy_start", 255, 255, 255, 128, 128, 128);

    // Reset asserted at T+5 aborts the evaluation.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort.busy", busy_a, 0);
    check("abort.en", en_a, 0);
    check_a("abort", 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    npulse_a = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (en_a) npulse_a++;
    end
    check("abort.npulse", npulse_a, 0);

    e1_up = 24'h00C864; e1_low = 24'h0; e2_up = 24'h003CB4; e2_low = 24'h0;
    run(0, 0);
    check("after_rst.pulse_at", pulse_a, 10);
    check_a("after_rst", 180, 60, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inferencia_t2.md
Name: inferencia_t2

Overview:
- Rule-evaluation stage of the interval type-2 fuzzy controller. Sits directly upstream of the type-reduction/defuzzifier.
- Takes the upper and lower membership degrees of two inputs (3 sets each) and evaluates the 9-rule base sequentially, one rule per clock.
- Each rule fires with a min t-norm; results aggregate by max into 3 output sets.
- Outputs FOU_1..3_UP/LOW plus a one-cycle EN_saida strobe that drives the defuzzifier's output-register enable.

Parameters:
REGRAS, 18'h29910, rule table; bits [2k+1:2k] = consequent code of rule k=3*i+j (i = input-1 set, j = input-2 set); codes 0,1,2 = output set 1,2,3; code 3 = rule disabled
LARG, 8, membership/firing width (fixed at 8 in this design)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request evaluation; sampled only in IDLE
E1_UP  in  24  input-1 upper degrees, set s at [8s+7:8s]
E1_LOW  in  24  input-1 lower degrees, same packing
E2_UP  in  24  input-2 upper degrees
E2_LOW  in  24  input-2 lower degrees
FOU_1_UP, FOU_2_UP, FOU_3_UP  out  8 each  aggregated upper firing per output set
FOU_1_LOW, FOU_2_LOW, FOU_3_LOW  out  8 each  aggregated lower firing per output set
EN_saida  out  1  one-cycle pulse, results updated
busy  out  1  high in EVAL and DONE

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset: FSM to IDLE, rule counter 0, accumulators 0, all FOU outputs 0, EN_saida 0, busy 0.
- FSM states:
  - IDLE: start=1 -> register all four input vectors, clear the 6 accumulators, counter k=0, go to EVAL.
  - EVAL: evaluate rule k each cycle; k increments 0..8; after k=8 go to DONE.
  - DONE: copy accumulators to FOU outputs, EN_saida=1 for exactly this cycle, go to IDLE.
- Latency: start sampled at edge T -> 9 EVAL cycles -> FOU outputs valid and EN_saida high in the cycle after edge T+10.
- Back-to-back: a new start is accepted in the cycle after DONE (11-cycle throughput).
- start while busy is ignored; no queueing.
- Input changes after the start sample have no effect on the running evaluation.
- Lower-bound clamp, applied on capture: low_eff = min(LOW, UP) per set, so every FOU_LOW <= FOU_UP always holds.
- Rule k (i = k/3, j = k%3, c = REGRAS[2k+1:2k]):
  - up_k = min(E1_UP[i], E2_UP[j]); low_k = min(E1_LOW_eff[i], E2_LOW_eff[j]).
  - If c != 3: acc_up[c] = max(acc_up[c], up_k) and acc_low[c] = max(acc_low[c], low_k).
  - If c == 3: no update, but the rule still consumes its cycle.
- Arithmetic: unsigned 8-bit compare/select only; no overflow is possible.
- An output set with no enabled rule reads 0.
- FOU outputs hold their value between DONE cycles; they do not change during EVAL.
- Reset asserted mid-EVAL: evaluation is aborted, outputs return to 0, and no EN_saida pulse is produced.

Decomposition:
- Shared package fuzzy_pkg: N_CONJ=3, N_REGRAS=9, LARG=8, REGRA_OFF=2'd3, REGRAS_PADRAO=18'h29910, FSM state encoding (IDLE/EVAL/DONE).
- Sub-module regra_t2: combinational; muxes set i/j from the packed vectors and outputs up_k/low_k via min. The top level keeps the FSM, counter and max accumulators.

Test Plan:
- Reset then idle -> all FOU = 0, EN_saida = 0, busy = 0.
- All sets UP=255, LOW=128, start -> EN_saida at T+10; FOU_1..3_UP = 255, FOU_1..3_LOW = 128.
- E1_UP={0,200,100} (sets 3..1), E2_UP={0,60,180}, all LOW=0 -> FOU_1_UP = 180 (max of 100,60,180), FOU_2_UP = 60, FOU_3_UP = 0, all LOW = 0.
- Inverted lows: E1 set1 UP=50/LOW=90, E2 set1 UP=200/LOW=200, others 0 -> FOU_1_UP = 50, FOU_1_LOW = 50 after clamp.
- REGRAS=18'h3FFFF (all disabled), any inputs -> all FOU = 0, EN_saida still pulses at T+10.
- Second start at T+4 ignored, one pulse at T+10. Separately, rst at T+5 -> outputs 0, no pulse; a fresh start after reset gives a correct result.
